// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache with one-word blocks, SETS frames, single outstanding fill.
// Optional 32-bit hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        iflush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int IDX  = $clog2(SETS);
   localparam int TAGW = 30 - IDX;

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [SETS-1:0] r_valid;
   logic [TAGW-1:0] r_tag  [SETS];
   logic [31:0]     r_data [SETS];
   logic [29:0]     r_miss_addr;

   logic [IDX-1:0]  w_idx;
   logic [IDX-1:0]  w_fill_idx;
   logic [TAGW-1:0] w_tag;
   logic [TAGW-1:0] w_fill_tag;
   logic            w_lookup;
   logic            w_hit;
   logic            w_miss;
   logic            w_fill;
   logic            w_unused;

   assign w_idx      = imemaddr[IDX+1:2];
   assign w_tag      = imemaddr[31:IDX+2];
   assign w_fill_idx = r_miss_addr[IDX-1:0];
   assign w_fill_tag = r_miss_addr[29:IDX];
   assign w_lookup   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_unused   = ^imemaddr[1:0];

   // State register; the fill buffer address is only captured on a miss.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_miss_addr <= 30'd0;
      end else begin
         r_state <= w_next_state;
         if (w_miss) begin
            r_miss_addr <= imemaddr[31:2];
         end
      end
   end

   // Next-state and request outputs; flush in IDLE suppresses both hit and miss.
   always_comb begin
      w_next_state = r_state;
      w_hit        = 1'b0;
      w_miss       = 1'b0;
      w_fill       = 1'b0;
      iREN         = 1'b0;
      iaddr        = 32'd0;
      case (r_state)
         IDLE: begin
            if (iflush) begin
               w_next_state = IDLE;
            end else if (imemREN && !w_lookup) begin
               w_miss       = 1'b1;
               w_next_state = FETCH;
            end else begin
               w_hit = imemREN && w_lookup;
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = {r_miss_addr, 2'b00};
            if (!iwait) begin
               w_fill       = 1'b1;
               w_next_state = IDLE;
            end else begin
               w_next_state = FETCH;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign ihit     = w_hit;
   assign imemload = w_hit ? r_data[w_idx] : 32'd0;

   // Valid bits: a fill landing with a flush survives, since it is the newer data.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_valid <= '0;
      end else begin
         if (iflush) begin
            r_valid <= '0;
         end
         if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; the valid bits qualify them.
   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   // Event counters wrap naturally and ignore flush.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         if (w_hit) begin
            hit_count <= hit_count + 32'd1;
         end
         if (w_miss) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule
